s4ga_cfg_streamer: RTL

Upstream feeder for the s4ga LUT-evaluation core. It holds the full LUT configuration image (N LUT frames of SI_W-bit segments) in an on-chip register file, loaded once over a valid/ready nibble port. On start it holds the core in reset for N+2 cycles, then streams the image to the core's si input endlessly, one segment per clock, wrapping frame N-1 back to frame 0. It drives the core's si and rst inputs, sharing its clock.

---
 rtl/s4ga_cfg_streamer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/s4ga_cfg_streamer.sv
// rtl/s4ga_cfg_streamer.sv - LUT configuration image store and endless segment streamer for the s4ga core
module s4ga_cfg_streamer #(
  parameter int N    = 89,
  parameter int K    = 5,
  parameter int SI_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_load,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  load_valid,
  input  logic [SI_W-1:0]       load_data,
  output logic                  load_ready,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic [SI_W-1:0]       s4_si,
  output logic                  s4_rst,
  output logic [$clog2(N)-1:0]  lut_idx,
  output logic                  pass_pulse,
  output logic [15:0]           pass_cnt
);

  localparam int IDX_W     = $clog2(N);
  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((2 ** K) + SI_W - 1) / SI_W;
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS;
  localparam int DEPTH     = N * SEGS;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int SEG_W     = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int RC_W      = $clog2(N + 2);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESET, S_RUN} state_t;

  state_t            state, state_d;
  logic [SI_W-1:0]   s4_si_d;
  logic              s4_rst_d, load_ready_d, cfg_valid_d, busy_d, pass_pulse_d;
  logic [IDX_W-1:0]  lut_idx_d;
  logic [15:0]       pass_cnt_d;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [SEG_W-1:0]  seg_cnt, seg_cnt_d;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
  logic              stop_req, stop_req_d;
  logic              mem_we;

  logic [SI_W-1:0]   mem [DEPTH];

  // Image storage carries no reset so a reset costs only the cfg_valid flag.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= load_data;
  end

  always_comb begin
    state_d      = state;
    s4_si_d      = s4_si;
    s4_rst_d     = s4_rst;
    load_ready_d = load_ready;
    cfg_valid_d  = cfg_valid;
    busy_d       = busy;
    lut_idx_d    = lut_idx;
    pass_pulse_d = 1'b0;
    pass_cnt_d   = pass_cnt;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    seg_cnt_d    = seg_cnt;
    rst_cnt_d    = rst_cnt;
    stop_req_d   = stop_req;
    mem_we       = 1'b0;
    case (state)
      S_IDLE: begin
        s4_rst_d = 1'b1;
        s4_si_d  = '0;
        if (cmd_load) begin
          state_d      = S_LOAD;
          wr_ptr_d     = '0;
          cfg_valid_d  = 1'b0;
          load_ready_d = 1'b1;
        end else if (cmd_start && cfg_valid) begin
          state_d    = S_RESET;
          busy_d     = 1'b1;
          rst_cnt_d  = '0;
          rd_ptr_d   = '0;
          seg_cnt_d  = '0;
          lut_idx_d  = '0;
          pass_cnt_d = '0;
          stop_req_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_valid && load_ready) begin
          mem_we = 1'b1;
          if (wr_ptr == PTR_LAST) begin
            state_d      = S_IDLE;
            wr_ptr_d     = '0;
            load_ready_d = 1'b0;
            cfg_valid_d  = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr + 1'b1;
          end
        end
      end
      S_RESET: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (rst_cnt == RC_LAST) begin
          state_d   = S_RUN;
          s4_rst_d  = 1'b0;
          s4_si_d   = mem[0];
          rd_ptr_d  = PTR_W'(1);
          seg_cnt_d = '0;
          lut_idx_d = '0;
        end else begin
          rst_cnt_d = rst_cnt + 1'b1;
        end
      end
      S_RUN: begin
        // seg_cnt/lut_idx describe the segment currently on s4_si.
        if ((stop_req || cmd_stop) && seg_cnt == SEG_LAST) begin
          state_d    = S_IDLE;
          s4_rst_d   = 1'b1;
          s4_si_d    = '0;
          busy_d     = 1'b0;
          stop_req_d = 1'b0;
          seg_cnt_d  = '0;
          lut_idx_d  = '0;
        end else begin
          stop_req_d   = stop_req || cmd_stop;
          s4_si_d      = mem[rd_ptr];
          rd_ptr_d     = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
          pass_pulse_d = (rd_ptr == PTR_LAST);
          if (rd_ptr == PTR_LAST) pass_cnt_d = pass_cnt + 16'd1;
          if (seg_cnt == SEG_LAST) begin
            seg_cnt_d = '0;
            lut_idx_d = (lut_idx == IDX_LAST) ? '0 : lut_idx + 1'b1;
          end else begin
            seg_cnt_d = seg_cnt + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      s4_si      <= '0;
      s4_rst     <= 1'b1;
      load_ready <= 1'b0;
      cfg_valid  <= 1'b0;
      busy       <= 1'b0;
      lut_idx    <= '0;
      pass_pulse <= 1'b0;
      pass_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seg_cnt    <= '0;
      rst_cnt    <= '0;
      stop_req   <= 1'b0;
    end else begin
      state      <= state_d;
      s4_si      <= s4_si_d;
      s4_rst     <= s4_rst_d;
      load_ready <= load_ready_d;
      cfg_valid  <= cfg_valid_d;
      busy       <= busy_d;
      lut_idx    <= lut_idx_d;
      pass_pulse <= pass_pulse_d;
      pass_cnt   <= pass_cnt_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      seg_cnt    <= seg_cnt_d;
      rst_cnt    <= rst_cnt_d;
      stop_req   <= stop_req_d;
    end
  end

endmodule
